hazard_control_unit: RTL and testbench

- Consumer-side control for the ID/EX pipeline register. It generates the clear (FlushE) that register samples, plus the stage stalls and flushes for the other pipeline registers.
- Consumes rs1E/rs2E/rdE/ResultSrcE from the E stage and produces the forwarding selects for the EX operand muxes.
- Adds a sequential data-memory wait sequencer for multi-cycle DMEM. Also keeps saturating stall/flush performance counters.
- Sits beside the datapath and is wired to every stage register and to the EX forwarding muxes.

---
 rtl/hazard_control_unit.sv | 152 +++++++++++++++
 tb/tb_hazard_control_unit.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/hazard_control_unit.sv
// Hazard control for a five-stage pipeline: EX operand forwarding, load-use
// interlock, control-flow flushes, a wait sequencer for multi-cycle data
// memory, and saturating stall/flush event counters.
//
// Handshake note: this block has no valid/ready pairs. Every output is a
// level that the stage registers sample on the next rising edge of clk.
module hazard_control_unit #(
    parameter int DMEM_LATENCY = 1,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs1D,
    input  logic [4:0]       rs2D,
    input  logic [4:0]       rs1E,
    input  logic [4:0]       rs2E,
    input  logic [4:0]       rdE,
    input  logic [1:0]       ResultSrcE,
    input  logic             PCSrcE,
    input  logic [4:0]       rdM,
    input  logic [4:0]       rdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemAccessM,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    // Wait counter only has to hold DMEM_LATENCY-2; keep at least one bit.
    localparam int            CW        = (DMEM_LATENCY > 2) ? $clog2(DMEM_LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT  = (DMEM_LATENCY > 2) ? CW'(DMEM_LATENCY - 2) : '0;
    localparam logic          MEM_MULTI = (DMEM_LATENCY > 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;
    logic             mem_stall;
    logic             lw_stall;

    // EX operand forwarding: M has the younger value so it beats W; x0 never forwards.
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (RegWriteM && (rdM != 5'd0) && (rdM == rs1E))      ForwardAE = 2'b10;
        else if (RegWriteW && (rdW != 5'd0) && (rdW == rs1E)) ForwardAE = 2'b01;
        if (RegWriteM && (rdM != 5'd0) && (rdM == rs2E))      ForwardBE = 2'b10;
        else if (RegWriteW && (rdW != 5'd0) && (rdW == rs2E)) ForwardBE = 2'b01;
    end

    // Load in E whose destination is read by the instruction in D.
    always_comb begin
        lw_stall = (ResultSrcE == 2'b01) && (rdE != 5'd0) && ((rdE == rs1D) || (rdE == rs2D));
    end

    // Memory-wait sequencer state and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: RELEASE always returns to RUN so the access that just
    // finished cannot re-trigger a wait while it is still in M.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (MemAccessM && MEM_MULTI) begin
                    cnt_d   = CNT_INIT;
                    state_d = (DMEM_LATENCY > 2) ? ST_WAIT : ST_RELEASE;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) state_d = ST_RELEASE;
            end
            ST_RELEASE: state_d = ST_RUN;
            default:    state_d = ST_RUN;
        endcase
    end

    // Stall/flush outputs: a memory wait freezes F..M and bubbles W, and
    // overrides load-use and redirect (both re-present once M drains).
    always_comb begin
        mem_stall = ((state_q == ST_RUN) && MemAccessM && MEM_MULTI) || (state_q == ST_WAIT);
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (!reset) begin
            if (mem_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else begin
                StallF = lw_stall;
                StallD = lw_stall;
                FlushD = PCSrcE;
                FlushE = lw_stall | PCSrcE;
            end
        end
    end

    // Saturating event counters: next values.
    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if ((StallF || StallM) && (stall_count_q != '1)) stall_count_d = stall_count_q + 1'b1;
        if (FlushD && (flush_count_q != '1))             flush_count_d = flush_count_q + 1'b1;
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign StallCount = stall_count_q;
    assign FlushCount = flush_count_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed test of hazard_control_unit built with DMEM_LATENCY=4, CNT_W=4.
// The driver pushes the hand-computed response for each cycle into a queue;
// a monitor on the falling edge pops and compares it against the DUT.
module tb_hazard_control_unit;

    localparam int LAT = 4;
    localparam int CW  = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [4:0]    rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic [1:0]    ResultSrcE;
    logic          PCSrcE, RegWriteM, RegWriteW, MemAccessM;
    logic [1:0]    ForwardAE, ForwardBE;
    logic          StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic [CW-1:0] StallCount, FlushCount;

    // Expected word: {fa, fb, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, sc, fc}
    logic [18:0]   exp_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            exp_sc   = 0;
    int            exp_fc   = 0;

    hazard_control_unit #(.DMEM_LATENCY(LAT), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
        .rdM(rdM), .rdW(rdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemAccessM(MemAccessM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .StallCount(StallCount), .FlushCount(FlushCount)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic clear_inputs();
        rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0; rdE = 0; rdM = 0; rdW = 0;
        ResultSrcE = 2'b00; PCSrcE = 0; RegWriteM = 0; RegWriteW = 0; MemAccessM = 0;
    endtask

    // Push this cycle's expected response, advance the counter model, step a cycle.
    // ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
    task automatic expect_cycle(input logic [1:0] fa, input logic [1:0] fb, input logic [6:0] ctl);
        exp_q.push_back({fa, fb, ctl, CW'(exp_sc), CW'(exp_fc)});
        if (reset) begin
            exp_sc = 0;
            exp_fc = 0;
        end else begin
            if ((ctl[6] || ctl[3]) && exp_sc < 15) exp_sc++;
            if (ctl[2] && exp_fc < 15)             exp_fc++;
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        logic [18:0] e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
                 StallCount, FlushCount};
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL cycle_check #%0d @%0t: got fa=%b fb=%b ctl=%b sc=%0d fc=%0d, expected fa=%b fb=%b ctl=%b sc=%0d fc=%0d",
                         n_checks, $time, a[18:17], a[16:15], a[14:8], a[7:4], a[3:0],
                         e[18:17], e[16:15], e[14:8], e[7:4], e[3:0]);
            end
        end
    end

    initial begin
        int guard;
        clear_inputs();
        reset = 1'b1;
        @(posedge clk); #1;

        // Reset state: outputs idle, counters cleared
        expect_cycle(2'b00, 2'b00, 7'b0000000);
        reset = 1'b0;

        // Forwarding: M beats W
        rdM = 5; RegWriteM = 1; rdW = 5; RegWriteW = 1; rs1E = 5;
        expect_cycle(2'b10, 2'b00, 7'b0000000);
        // rdM = x0 -> W source
        rdM = 0;
        expect_cycle(2'b01, 2'b00, 7'b0000000);
        // Everything targets x0 -> no forwarding
        rs1E = 0; rdW = 0;
        expect_cycle(2'b00, 2'b00, 7'b0000000);
        // Operand B from M, W not writing
        rdM = 3; RegWriteM = 1; rdW = 3; RegWriteW = 0; rs2E = 3;
        expect_cycle(2'b00, 2'b10, 7'b0000000);
        // Operand B from W when M not writing
        RegWriteM = 0; RegWriteW = 1;
        expect_cycle(2'b00, 2'b01, 7'b0000000);
        clear_inputs();

        // Load-use on rs2D
        ResultSrcE = 2'b01; rdE = 7; rs2D = 7;
        expect_cycle(2'b00, 2'b00, 7'b1100010);
        // Not a load -> no interlock; StallCount shows 1
        ResultSrcE = 2'b10;
        expect_cycle(2'b00, 2'b00, 7'b0000000);
        // Load to x0 never interlocks
        ResultSrcE = 2'b01; rdE = 0; rs1D = 0; rs2D = 0;
        expect_cycle(2'b00, 2'b00, 7'b0000000);
        clear_inputs();

        // Redirect alone
        PCSrcE = 1;
        expect_cycle(2'b00, 2'b00, 7'b0000110);
        // Redirect together with load-use on rs1D
        ResultSrcE = 2'b01; rdE = 9; rs1D = 9;
        expect_cycle(2'b00, 2'b00, 7'b1100110);
        clear_inputs();
        expect_cycle(2'b00, 2'b00, 7'b0000000);

        // Memory access held high: 3 stall cycles, release, then a fresh 3-cycle stall
        MemAccessM = 1;
        expect_cycle(2'b00, 2'b00, 7'b1111001);
        expect_cycle(2'b00, 2'b00, 7'b1111001);
        expect_cycle(2'b00, 2'b00, 7'b1111001);
        expect_cycle(2'b00, 2'b00, 7'b0000000);
        expect_cycle(2'b00, 2'b00, 7'b1111001);
        // Redirect and load-use are ignored while waiting
        PCSrcE = 1; ResultSrcE = 2'b01; rdE = 4; rs1D = 4;
        expect_cycle(2'b00, 2'b00, 7'b1111001);
        ResultSrcE = 2'b00;
        expect_cycle(2'b00, 2'b00, 7'b1111001);
        // Release: redirect now honoured
        MemAccessM = 0;
        expect_cycle(2'b00, 2'b00, 7'b0000110);
        clear_inputs();

        // Reset in the middle of a wait
        MemAccessM = 1;
        expect_cycle(2'b00, 2'b00, 7'b1111001);
        expect_cycle(2'b00, 2'b00, 7'b1111001);
        reset = 1'b1; MemAccessM = 0;
        expect_cycle(2'b00, 2'b00, 7'b0000000);
        reset = 1'b0;
        expect_cycle(2'b00, 2'b00, 7'b0000000);
        expect_cycle(2'b00, 2'b00, 7'b0000000);

        // Saturation: 18 stall cycles into a 4-bit counter
        MemAccessM = 1;
        for (int i = 0; i < 24; i++)
            expect_cycle(2'b00, 2'b00, (i % 4 != 3) ? 7'b1111001 : 7'b0000000);
        clear_inputs();
        ResultSrcE = 2'b01; rdE = 2; rs1D = 2;
        expect_cycle(2'b00, 2'b00, 7'b1100010);
        clear_inputs();
        expect_cycle(2'b00, 2'b00, 7'b0000000);
        expect_cycle(2'b00, 2'b00, 7'b0000000);

        // Drain the scoreboard with a bounded wait
        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
